// File: rtl/eth_transmitter_core.sv
`default_nettype none
// ============================================================================
// Module   : eth_transmitter_core
// Purpose  : Memory-mapped Ethernet transmit engine. An asynchronous CPU bus
//            fills a 1 KiB frame buffer. A write to TX_RST streams the whole
//            buffer out LSB first over a transmit-only SPI link
//            (tx_sck / tx_mosi). CR bit 1 reports transmitter idle.
// Revision : 1.0 - initial release
// ============================================================================
module eth_transmitter_core (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_we,
  input  logic        n_oe,
  output logic        n_rdy,
  output logic        tx_sck,
  output logic        tx_mosi
);

  // Fixed register map
  localparam logic [5:0]  C_BUF_PAGE  = 6'b111100;   // 0xF000..0xF3FF
  localparam logic [15:0] C_CR_ADDR   = 16'hFB00;
  localparam logic [15:0] C_TXRST_ADR = 16'hFB01;
  localparam logic [9:0]  C_LAST_OFS  = 10'h3FF;
  localparam logic [2:0]  C_LAST_BIT  = 3'd7;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // --------------------------------------------------------------------------
  // Bus strobe synchronizers
  // --------------------------------------------------------------------------
  logic [1:0] we_sync;
  logic [1:0] oe_sync;
  logic       we_s;
  logic       oe_s;

  // Two-flop synchronizers; strobes are inactive (high) out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we_sync <= 2'b11;
      oe_sync <= 2'b11;
    end else begin
      we_sync <= {we_sync[0], n_we};
      oe_sync <= {oe_sync[0], n_oe};
    end
  end

  assign we_s = we_sync[1];
  assign oe_s = oe_sync[1];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic sel_buf;
  logic sel_cr;
  logic sel_txrst;
  logic sel_any;

  assign sel_buf   = (a[15:10] == C_BUF_PAGE);
  assign sel_cr    = (a == C_CR_ADDR);
  assign sel_txrst = (a == C_TXRST_ADR);
  assign sel_any   = sel_buf | sel_cr | sel_txrst;

  // --------------------------------------------------------------------------
  // Bus handshake FSM: one access per strobe, acknowledged until both
  // strobes are released. The commit pulse fires exactly once per n_we.
  // --------------------------------------------------------------------------
  bus_state_t bus_state;
  bus_state_t bus_next;
  logic       bus_commit;

  // Bus handshake state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus_state <= BUS_IDLE;
    end else begin
      bus_state <= bus_next;
    end
  end

  // Bus next-state logic and the single-cycle write commit.
  always_comb begin
    bus_next   = bus_state;
    bus_commit = 1'b0;
    case (bus_state)
      BUS_IDLE: begin
        if (!we_s || !oe_s) begin
          bus_next   = BUS_ACK;
          bus_commit = !we_s;
        end
      end
      BUS_ACK: begin
        if (we_s && oe_s) begin
          bus_next = BUS_IDLE;
        end
      end
      default: bus_next = BUS_IDLE;
    endcase
  end

  // n_rdy is a direct decode of a single flop, so it cannot glitch.
  assign n_rdy = (bus_state == BUS_IDLE);

  logic wr_buf;
  logic wr_txrst;

  // Unmapped and CR writes fall through both selects and are dropped.
  assign wr_buf   = bus_commit & sel_buf;
  assign wr_txrst = bus_commit & sel_txrst;

  // --------------------------------------------------------------------------
  // Frame buffer
  // --------------------------------------------------------------------------
  logic [7:0] mem [0:1023];

  // Buffer write port; contents have no defined reset value.
  always_ff @(posedge clk) begin
    if (wr_buf) begin
      mem[a[9:0]] <= d;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  tx_state_t  tx_state;
  tx_state_t  tx_next;
  logic [9:0] offset;
  logic [2:0] bit_idx;
  logic [7:0] cur_byte;
  logic       last_bit;
  logic       tx_rdy;

  // The byte is read from the buffer at each bit, so a buffer write that
  // lands before a byte's turn is transmitted with its new value.
  assign cur_byte = mem[offset];
  assign last_bit = (offset == C_LAST_OFS) && (bit_idx == C_LAST_BIT);
  assign tx_rdy   = (tx_state == TX_IDLE);

  // Transmit state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  // Transmit next-state: TX_RST always (re)starts; the frame ends on the
  // falling sck edge of bit 7 of the last byte.
  always_comb begin
    tx_next = tx_state;
    if (wr_txrst) begin
      tx_next = TX_SHIFT;
    end else begin
      case (tx_state)
        TX_IDLE:  tx_next = TX_IDLE;
        TX_SHIFT: begin
          if (tx_sck && last_bit) begin
            tx_next = TX_IDLE;
          end
        end
        default:  tx_next = TX_IDLE;
      endcase
    end
  end

  // Serializer datapath. Each bit is one low clk followed by one high clk.
  // mosi is loaded on the edge that ends the low phase, so it is settled
  // for the entire high phase and through the sampling falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      offset  <= '0;
      bit_idx <= '0;
      tx_sck  <= 1'b0;
      tx_mosi <= 1'b0;
    end else if (wr_txrst) begin
      offset  <= '0;
      bit_idx <= '0;
      tx_sck  <= 1'b0;
    end else if (tx_state == TX_SHIFT) begin
      if (!tx_sck) begin
        tx_sck  <= 1'b1;
        tx_mosi <= cur_byte[bit_idx];
      end else begin
        tx_sck <= 1'b0;
        if (!last_bit) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == C_LAST_BIT) begin
            offset <= offset + 10'd1;
          end
        end
      end
    end else begin
      tx_sck  <= 1'b0;
      tx_mosi <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: combinational while n_oe is low and the address decodes
  // --------------------------------------------------------------------------
  logic [7:0] rd_data;
  logic       rd_drive;

  // Read data multiplexer; TX_RST and unselected addresses read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (sel_buf) begin
      rd_data = mem[a[9:0]];
    end else if (sel_cr) begin
      rd_data = {6'b000000, tx_rdy, 1'b0};
    end
  end

  assign rd_drive = !n_oe && sel_any;
  assign d        = rd_drive ? rd_data : 8'bzzzzzzzz;

endmodule
`default_nettype wire

// File: tb/tb_eth_transmitter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_transmitter_core
// Purpose  : Bench for eth_transmitter_core: bus accesses with randomized
//            strobe timing, frame capture on tx_sck falling edges compared
//            against a byte-array model of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_transmitter_core;

  localparam int CLK_HALF = 25;   // 20 MHz
  localparam int FRAME_BITS = 8192;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        drive = 1'b0;
  logic        n_we = 1'b1;
  logic        n_oe = 1'b1;
  wire  [7:0]  d;
  wire         n_rdy;
  wire         tx_sck;
  wire         tx_mosi;

  int  total = 0;
  int  bad = 0;
  int  falls = 0;
  int  rises = 0;
  time first_rise = 0;
  time ack_time = 0;
  bit  bq[$];
  logic [7:0] model_mem [0:1023];

  assign d = drive ? wdata : 8'bzzzzzzzz;

  // Pull-ups make an undriven bus read back as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (d[i]);
  end

  eth_transmitter_core dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .a       (a),
    .d       (d),
    .n_we    (n_we),
    .n_oe    (n_oe),
    .n_rdy   (n_rdy),
    .tx_sck  (tx_sck),
    .tx_mosi (tx_mosi)
  );

  always #CLK_HALF clk = ~clk;

  // Receiver: sample mosi on each falling sck edge.
  always @(negedge tx_sck) begin
    bq.push_back(tx_mosi);
    falls++;
  end

  // Count rising sck edges and remember the first one of a run.
  always @(posedge tx_sck) begin
    if (rises == 0) first_rise = $time;
    rises++;
  end

  initial begin
    #(90000 * 2 * CLK_HALF);
    $display("FAIL watchdog: simulation time limit reached, falls=%0d", falls);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pattern(input int k);
    return 8'((((k & 255) + 1) * 239 + (k >> 2) * 113) & 255);
  endfunction

  function automatic bit model_bit(input int j);
    logic [7:0] b;
    b = model_mem[j >> 3];
    return b[j & 7];
  endfunction

  function automatic logic [7:0] get_byte(input int start);
    logic [7:0] b;
    b = 8'hxx;
    if (start >= 0 && start + 8 <= bq.size()) begin
      for (int k = 0; k < 8; k++) b[k] = bq[start + k];
    end
    return b;
  endfunction

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    a = addr; wdata = data; drive = 1'b1;
    #(400 + $urandom_range(1, 20));
    n_we = 1'b0;
    n = 0;
    while (n_rdy !== 1'b0 && n < 4) begin @(posedge clk); #1; n++; end
    ack_time = $time;
    total++;
    if (n_rdy !== 1'b0) begin
      bad++;
      $display("FAIL wr_ack addr=%h n_rdy=%b after %0d clk, want 0", addr, n_rdy, n);
    end
    n_we = 1'b1;
    n = 0;
    while (n_rdy !== 1'b1 && n < 3) begin @(posedge clk); #1; n++; end
    total++;
    if (n_rdy !== 1'b1) begin
      bad++;
      $display("FAIL wr_release addr=%h n_rdy=%b after %0d clk, want 1", addr, n_rdy, n);
    end
    #400;
    drive = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] val);
    int n;
    @(negedge clk);
    a = addr; drive = 1'b0;
    #(400 + $urandom_range(1, 20));
    n_oe = 1'b0;
    n = 0;
    while (n_rdy !== 1'b0 && n < 4) begin @(posedge clk); #1; n++; end
    total++;
    if (n_rdy !== 1'b0) begin
      bad++;
      $display("FAIL rd_ack addr=%h n_rdy=%b after %0d clk, want 0", addr, n_rdy, n);
    end
    val = d;
    n_oe = 1'b1;
    n = 0;
    while (n_rdy !== 1'b1 && n < 3) begin @(posedge clk); #1; n++; end
    total++;
    if (n_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rd_release addr=%h n_rdy=%b after %0d clk, want 1", addr, n_rdy, n);
    end
    #400;
  endtask

  task automatic wait_falls(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (falls < target && n < budget) begin @(posedge clk); #1; n++; end
    ok = (falls >= target);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int r0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (tx_sck !== 1'b0 || tx_mosi !== 1'b0) begin
      bad++;
      $display("FAIL reset_spi sck=%b mosi=%b, want 0/0", tx_sck, tx_mosi);
    end
    total++;
    if (n_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_n_rdy got=%b want=1", n_rdy);
    end
    total++;
    if (d !== 8'hFF) begin
      bad++;
      $display("FAIL reset_d_undriven got=%h want=ff", d);
    end
    bus_read(16'hFB00, v);
    total++;
    if (v !== 8'h02) begin
      bad++;
      $display("FAIL reset_cr got=%h want=02", v);
    end
    r0 = rises;
    repeat (1000) @(posedge clk);
    total++;
    if (rises !== r0) begin
      bad++;
      $display("FAIL reset_quiet sck_rises=%0d want=%0d", rises, r0);
    end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    for (int k = 0; k < 1024; k++) begin
      model_mem[k] = pattern(k);
      bus_write(16'hF000 | 16'(k), model_mem[k]);
    end
    bus_read(16'hF000, v);
    total++;
    if (v !== 8'hEF) begin bad++; $display("FAIL fill_ofs0 got=%h want=ef", v); end
    bus_read(16'hF001, v);
    total++;
    if (v !== 8'hDE) begin bad++; $display("FAIL fill_ofs1 got=%h want=de", v); end
    bus_read(16'hF004, v);
    total++;
    if (v !== 8'h1C) begin bad++; $display("FAIL fill_ofs4 got=%h want=1c", v); end
  endtask

  task automatic test_frame();
    bit ok;
    int n;
    int nbad;
    int r0;
    logic [7:0] b;
    bq.delete(); falls = 0; rises = 0;
    bus_write(16'hFB01, 8'h00);
    total++;
    if (rises == 0 || first_rise - ack_time > 4 * 2 * CLK_HALF) begin
      bad++;
      $display("FAIL frame_latency first_rise=%0t ack=%0t rises=%0d", first_rise, ack_time, rises);
    end
    // Hold a CR read open across the end of the frame.
    @(negedge clk);
    a = 16'hFB00; n_oe = 1'b0;
    n = 0;
    while (n_rdy !== 1'b0 && n < 4) begin @(posedge clk); #1; n++; end
    total++;
    if (d[1] !== 1'b0) begin bad++; $display("FAIL frame_cr_busy got=%b want=0", d[1]); end
    wait_falls(FRAME_BITS, 17000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL frame_timeout falls=%0d want=%0d", falls, FRAME_BITS); end
    n = 0;
    while (d[1] !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    total++;
    if (d[1] !== 1'b1) begin bad++; $display("FAIL frame_cr_idle got=%b want=1 after %0d clk", d[1], n); end
    n_oe = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (tx_mosi !== 1'b0 || tx_sck !== 1'b0) begin
      bad++;
      $display("FAIL frame_end_lines sck=%b mosi=%b want 0/0", tx_sck, tx_mosi);
    end
    nbad = 0;
    for (int j = 0; j < 1024; j++) begin
      b = get_byte(j * 8);
      if (b !== model_mem[j]) nbad++;
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL frame_bytes bad_bytes=%0d byte0=%h want=%h", nbad, get_byte(0), model_mem[0]);
    end
    r0 = rises;
    repeat (1000) @(posedge clk);
    total++;
    if (bq.size() != FRAME_BITS || rises != r0 || rises != FRAME_BITS) begin
      bad++;
      $display("FAIL frame_count bits=%0d rises=%0d want=%0d and no more", bq.size(), rises, FRAME_BITS);
    end
  endtask

  task automatic test_restart();
    bit ok;
    int n;
    int nb;
    int nbad;
    bq.delete(); falls = 0; rises = 0;
    bus_write(16'hFB01, 8'h00);
    wait_falls(800, 2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL restart_wait100 falls=%0d want=800", falls); end
    bus_write(16'hFB01, 8'($urandom));
    wait_falls(800 + FRAME_BITS, 18000, ok);
    n = 0;
    while (n < 400) begin
      int lo;
      lo = 0;
      while (tx_sck === 1'b0 && lo < 8) begin @(posedge clk); #1; lo++; end
      if (lo >= 8) break;
      @(posedge clk); #1; n++;
    end
    nb = bq.size() - FRAME_BITS;
    total++;
    if (!ok || nb < 800 || nb > 800 + 64) begin
      bad++;
      $display("FAIL restart_point bits_before=%0d want 800..864 total=%0d", nb, bq.size());
    end
    nbad = 0;
    for (int j = 0; j < nb; j++) if (bq[j] !== model_bit(j)) nbad++;
    total++;
    if (nbad != 0) begin bad++; $display("FAIL restart_prefix bad_bits=%0d want=0", nbad); end
    total++;
    if (get_byte(nb) !== 8'hEF) begin
      bad++;
      $display("FAIL restart_first got=%h want=ef", get_byte(nb));
    end
    nbad = 0;
    for (int j = 0; j < 1024; j++) if (get_byte(nb + j * 8) !== model_mem[j]) nbad++;
    total++;
    if (nbad != 0) begin bad++; $display("FAIL restart_frame bad_bytes=%0d want=0", nbad); end
  endtask

  task automatic test_buffer_rw();
    logic [7:0] v;
    logic [9:0] ad [8];
    bus_write(16'hF123, 8'h5A);
    model_mem[10'h123] = 8'h5A;
    bus_read(16'hF123, v);
    total++;
    if (v !== 8'h5A) begin bad++; $display("FAIL rw_f123 got=%h want=5a", v); end
    for (int i = 0; i < 8; i++) begin
      ad[i] = 10'($urandom_range(0, 1023));
      model_mem[ad[i]] = 8'($urandom);
      bus_write(16'hF000 | 16'(ad[i]), model_mem[ad[i]]);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(16'hF000 | 16'(ad[i]), v);
      total++;
      if (v !== model_mem[ad[i]]) begin
        bad++;
        $display("FAIL rw_random ofs=%h got=%h want=%h", ad[i], v, model_mem[ad[i]]);
      end
    end
    bus_read(16'hFB01, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL rw_txrst_read got=%h want=00", v); end
  endtask

  task automatic test_unmapped();
    logic [7:0] v;
    int r0;
    bus_read(16'h1234, v);
    total++;
    if (v !== 8'hFF) begin bad++; $display("FAIL unmapped_read got=%h want=ff (undriven)", v); end
    bus_write(16'h1234, ~model_mem[10'h234]);
    bus_read(16'hF234, v);
    total++;
    if (v !== model_mem[10'h234]) begin
      bad++;
      $display("FAIL unmapped_write_alias got=%h want=%h", v, model_mem[10'h234]);
    end
    r0 = rises;
    bus_write(16'hFB00, ~model_mem[10'h300]);
    repeat (50) @(posedge clk);
    total++;
    if (rises != r0) begin bad++; $display("FAIL cr_write_started rises=%0d want=%0d", rises, r0); end
    bus_read(16'hF300, v);
    total++;
    if (v !== model_mem[10'h300]) begin
      bad++;
      $display("FAIL cr_write_alias got=%h want=%h", v, model_mem[10'h300]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int r0;
    logic [7:0] v;
    bq.delete(); falls = 0; rises = 0;
    bus_write(16'hFB01, 8'h00);
    wait_falls(200 + $urandom_range(0, 15), 1000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL areset_wait falls=%0d want>=200", falls); end
    @(posedge clk);
    #13;
    n_rst = 1'b0;
    #1;
    total++;
    if (tx_sck !== 1'b0 || tx_mosi !== 1'b0 || n_rdy !== 1'b1) begin
      bad++;
      $display("FAIL areset_now sck=%b mosi=%b n_rdy=%b want 0/0/1", tx_sck, tx_mosi, n_rdy);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    r0 = rises;
    bus_read(16'hFB00, v);
    total++;
    if (v !== 8'h02) begin bad++; $display("FAIL areset_cr got=%h want=02", v); end
    repeat (1000) @(posedge clk);
    total++;
    if (rises != r0) begin bad++; $display("FAIL areset_quiet rises=%0d want=%0d", rises, r0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_frame();
    test_restart();
    test_buffer_rw();
    test_unmapped();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_transmitter_core.md
# eth_transmitter_core

Memory-mapped Ethernet transmit engine. A CPU-side asynchronous bus loads a 1 KiB frame buffer. A write to a command register then streams the whole buffer out over a transmit-only SPI link (`tx_sck`/`tx_mosi`) to the Ethernet PHY/MAC. A status register lets software poll for transmitter idle.

## Interface
- No parameters. Map is fixed: buffer 0xF000–0xF3FF, CR 0xFB00, TX_RST 0xFB01.
- One clock; reset is asynchronous and active-low.

Ports:
- `clk` in 1: system clock, ≥20 MHz; all state is on its rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `a` in 16: bus address.
- `d` inout 8: bus data; driven only during decoded reads.
- `n_we` in 1: active-low write strobe, asynchronous to `clk`.
- `n_oe` in 1: active-low read strobe, asynchronous to `clk`.
- `n_rdy` out 1: active-low access-complete handshake.
- `tx_sck` out 1: SPI clock, idle low.
- `tx_mosi` out 1: SPI data, LSB first.

## Operation
- **Buffer write.** Writing 0xF000–0xF3FF stores `d` at offset `a[9:0]`.
- **Buffer read.** Reading 0xF000–0xF3FF returns the stored byte.
- **CR read (0xFB00).**
  - Bit 1 = TX_RDY: 1 = idle, 0 = transmitting.
  - All other bits read 0.
  - Writes to CR are ignored.
- **TX_RST write (0xFB01).**
  - Any data value; data is ignored.
  - Resets the transmit offset to 0, clears TX_RDY and starts transmission of all 1024 bytes.
  - A write while busy aborts the current byte and restarts from offset 0.
  - A read of TX_RST returns 0x00.
- **Unmapped addresses.** Writes are ignored. Reads leave `d` high-Z. `n_rdy` is still asserted so the bus never hangs.
- **Buffer writes during transmission** are permitted. A byte written before its turn is sent with the new value.
- **Serializer.**
  - Bytes are sent in offset order 0..1023, back-to-back, LSB first.
  - `tx_mosi` changes only while `tx_sck` is low. It is stable through the high phase and the falling edge.
  - The receiver samples on the falling edge.
  - After bit 7 of offset 1023, `tx_sck` stays low (no extra pulses), TX_RDY returns to 1 and `tx_mosi` returns to 0.
- **States.**
  - IDLE → SHIFT on a TX_RST write.
  - SHIFT loops over bits and bytes.
  - SHIFT → IDLE after the last bit's falling edge.
  - Any state → SHIFT(offset 0) on a TX_RST write.
  - Any state → IDLE on reset.
- **Reset values.** `tx_sck`=0, `tx_mosi`=0, `n_rdy`=1, `d` high-Z, TX_RDY=1, state IDLE. Buffer contents are undefined.

## Timing
- **Synchronization.** `n_we` and `n_oe` pass through a 2-flop synchronizer.
- **Write.**
  - `a` and `d` are stable from ≥400 ns before `n_we` falls until ≥400 ns after it rises.
  - The write commits within 3 clk after the synchronized falling edge.
  - `n_rdy` goes low ≤4 clk after `n_we` falls.
  - The write occurs exactly once per strobe.
- **Read.**
  - `d` is driven combinationally while `n_oe`=0 and the address decodes.
  - Data is valid before `n_rdy` falls.
  - `n_rdy` goes low ≤4 clk after `n_oe` falls.
- **Handshake release.** `n_rdy` returns high ≤3 clk after both strobes are high.
- **SPI bit timing.** `tx_sck` period = 2 clk (1 high, 1 low). One bit per period, no inter-byte gap.
- **Latency.** First `tx_sck` rising edge ≤4 clk after the TX_RST write commits.
- **Full frame.** 8192 sck periods; at 20 MHz this is ≈0.82 ms.

## Test plan
- Reset, then read CR → bit1 = 1; `tx_sck`=0 and `tx_mosi`=0; no sck activity for 50 µs.
- Fill offset k with ((k[7:0]+1)·239 + k[9:2]·113) mod 256, e.g. offset 0=0xEF, 1=0xDE, 4=0x1C. Write 0x00 to 0xFB01. Capture LSB-first on `tx_sck` falling edges → exactly 1024 bytes matching the pattern, then no further sck edges for 50 µs.
- Poll CR during transmission → bit1=0. After the last byte → bit1=1 within 4 clk.
- Write 0x5A to 0xF123, then read 0xF123 → 0x5A. Read 0x1234 → `d` high-Z and `n_rdy` still asserted.
- Write TX_RST mid-frame (after 100 bytes) → stream restarts at offset 0 with 0xEF and completes 1024 bytes; total bytes observed = 100 + partial + 1024.
- Assert `n_rst` mid-transmission → `tx_sck`/`tx_mosi` go 0 immediately, `n_rdy`=1, CR bit1=1 after release, no further sck.
